frame_stats_monitor: RTL and testbench

Per-frame pixel statistics and video-timing checker on the 48 MHz system clock, directly downstream of the NanEye receive path. It consumes the PAR_RAW / PCLK / H_SYNC / V_SYNC pixel bus produced by the deserializer and, at each frame end, publishes sum, min, max, line and pixel counts, and error flags. It feeds exposure control and frame-health reporting.

---
 rtl/frame_stats_monitor.sv | 186 ++++++++++++++++++
 tb/tb_frame_stats_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stats_monitor.sv
// Per-frame pixel statistics and video-timing checker for the NanEye pixel bus.
// Inputs are double-synchronised into CLOCK, edge-detected into registered event
// flags, and accumulated per frame; results are published at frame end.
module frame_stats_monitor #(
   parameter int unsigned D_WIDTH        = 10,
   parameter int unsigned C_ROWS         = 320,
   parameter int unsigned C_COLUMNS      = 320,
   parameter int unsigned TIMEOUT_CYCLES = 4800000
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic [D_WIDTH-1:0]   PAR_RAW,
   input  logic                 PCLK,
   input  logic                 H_SYNC,
   input  logic                 V_SYNC,
   output logic                 STAT_VALID,
   output logic [D_WIDTH+16:0]  PIX_SUM,
   output logic [D_WIDTH-1:0]   PIX_MIN,
   output logic [D_WIDTH-1:0]   PIX_MAX,
   output logic [10:0]          LINE_CNT,
   output logic [15:0]          FRAME_CNT,
   output logic                 LINE_LEN_ERR,
   output logic                 FRAME_LEN_ERR,
   output logic                 TIMEOUT_ERR
);

   localparam int unsigned SW = D_WIDTH + 17;
   localparam logic [22:0] TmoLast = 23'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StFrame} state_e;

   // Control bits packed as {V_SYNC, H_SYNC, PCLK}
   logic [2:0]         ctl1_q, ctl2_q, ctl3_q;
   logic [D_WIDTH-1:0] data1_q, data2_q, pix_q;
   logic               pix_ev_q, hs_fall_q, hs_lvl_q, vs_rise_q, vs_fall_q;

   state_e             state_q, state_d;
   logic [SW-1:0]      sum_q, sum_d;
   logic [SW:0]        sum_ext;
   logic [D_WIDTH-1:0] min_q, min_d, max_q, max_d;
   logic [10:0]        pcnt_q, pcnt_d, lcnt_q, lcnt_d;
   logic               lerr_q, lerr_d;
   logic [22:0]        tmo_q, tmo_d;
   logic               publish, timeout_hit;

   logic               stat_valid_q;
   logic [SW-1:0]      out_sum_q;
   logic [D_WIDTH-1:0] out_min_q, out_max_q;
   logic [10:0]        out_lcnt_q;
   logic [15:0]        out_fcnt_q;
   logic               out_lerr_q, out_ferr_q, out_tmo_q;

   // Synchroniser chain plus registered edge events, all with equal latency
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ctl1_q    <= '0;
         ctl2_q    <= '0;
         ctl3_q    <= '0;
         data1_q   <= '0;
         data2_q   <= '0;
         pix_q     <= '0;
         pix_ev_q  <= 1'b0;
         hs_fall_q <= 1'b0;
         hs_lvl_q  <= 1'b0;
         vs_rise_q <= 1'b0;
         vs_fall_q <= 1'b0;
      end else begin
         ctl1_q    <= {V_SYNC, H_SYNC, PCLK};
         ctl2_q    <= ctl1_q;
         ctl3_q    <= ctl2_q;
         data1_q   <= PAR_RAW;
         data2_q   <= data1_q;
         pix_q     <= data2_q;
         pix_ev_q  <= ctl2_q[0] & ~ctl3_q[0] & ctl2_q[1];
         hs_fall_q <= ~ctl2_q[1] & ctl3_q[1];
         hs_lvl_q  <= ctl2_q[1];
         vs_rise_q <= ctl2_q[2] & ~ctl3_q[2];
         vs_fall_q <= ~ctl2_q[2] & ctl3_q[2];
      end
   end

   // Frame FSM: accumulate pixels, close lines, decide when to publish
   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      min_d       = min_q;
      max_d       = max_q;
      pcnt_d      = pcnt_q;
      lcnt_d      = lcnt_q;
      lerr_d      = lerr_q;
      tmo_d       = tmo_q;
      sum_ext     = '0;
      publish     = 1'b0;
      timeout_hit = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (vs_rise_q) begin
               state_d = StFrame;
               sum_d   = '0;
               min_d   = '1;
               max_d   = '0;
               pcnt_d  = '0;
               lcnt_d  = '0;
               lerr_d  = 1'b0;
               tmo_d   = '0;
            end
         end
         StFrame: begin
            tmo_d = tmo_q + 23'd1;
            if (pix_ev_q) begin
               sum_ext = {1'b0, sum_q} + {{(SW + 1 - D_WIDTH){1'b0}}, pix_q};
               sum_d   = sum_ext[SW] ? '1 : sum_ext[SW-1:0];
               if (pix_q < min_q) min_d = pix_q;
               if (pix_q > max_q) max_d = pix_q;
               if (pcnt_q != '1) pcnt_d = pcnt_q + 11'd1;
            end
            // A line still open when V_SYNC falls is closed before publishing
            if (hs_fall_q || (vs_fall_q && hs_lvl_q)) begin
               if (lcnt_q != '1) lcnt_d = lcnt_q + 11'd1;
               if (pcnt_d != 11'(C_COLUMNS)) lerr_d = 1'b1;
               pcnt_d = '0;
            end
            if (vs_fall_q || (tmo_q == TmoLast)) begin
               publish     = 1'b1;
               timeout_hit = ~vs_fall_q;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Working state and published result registers
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q      <= StIdle;
         sum_q        <= '0;
         min_q        <= '1;
         max_q        <= '0;
         pcnt_q       <= '0;
         lcnt_q       <= '0;
         lerr_q       <= 1'b0;
         tmo_q        <= '0;
         stat_valid_q <= 1'b0;
         out_sum_q    <= '0;
         out_min_q    <= '1;
         out_max_q    <= '0;
         out_lcnt_q   <= '0;
         out_fcnt_q   <= '0;
         out_lerr_q   <= 1'b0;
         out_ferr_q   <= 1'b0;
         out_tmo_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sum_q        <= sum_d;
         min_q        <= min_d;
         max_q        <= max_d;
         pcnt_q       <= pcnt_d;
         lcnt_q       <= lcnt_d;
         lerr_q       <= lerr_d;
         tmo_q        <= tmo_d;
         stat_valid_q <= publish;
         if (publish) begin
            out_sum_q  <= sum_d;
            out_min_q  <= min_d;
            out_max_q  <= max_d;
            out_lcnt_q <= lcnt_d;
            out_fcnt_q <= out_fcnt_q + 16'd1;
            out_lerr_q <= lerr_d;
            out_ferr_q <= (lcnt_d != 11'(C_ROWS));
            out_tmo_q  <= timeout_hit;
         end
      end
   end

   assign STAT_VALID    = stat_valid_q;
   assign PIX_SUM       = out_sum_q;
   assign PIX_MIN       = out_min_q;
   assign PIX_MAX       = out_max_q;
   assign LINE_CNT      = out_lcnt_q;
   assign FRAME_CNT     = out_fcnt_q;
   assign LINE_LEN_ERR  = out_lerr_q;
   assign FRAME_LEN_ERR = out_ferr_q;
   assign TIMEOUT_ERR   = out_tmo_q;

endmodule

// File: tb/tb_frame_stats_monitor.sv
// Bench for frame_stats_monitor: drives pixel-bus frames and compares every
// publish against statistics computed from the list of pixels actually sent.
module tb_frame_stats_monitor;

   localparam int unsigned DW   = 10;
   localparam int unsigned ROWS = 4;
   localparam int unsigned COLS = 4;
   localparam int unsigned TMO  = 1000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] par_raw = '0;
   logic          pclk = 1'b0, hsync = 1'b0, vsync = 1'b0;
   logic          stat_valid;
   logic [DW+16:0] pix_sum;
   logic [DW-1:0] pix_min, pix_max;
   logic [10:0]   line_cnt;
   logic [15:0]   frame_cnt;
   logic          line_len_err, frame_len_err, timeout_err;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int exp_pulses = 0;
   int exp_frames = 0;
   int pix_vals[$];
   int line_lens[$];

   frame_stats_monitor #(
      .D_WIDTH(DW), .C_ROWS(ROWS), .C_COLUMNS(COLS), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLOCK(clk), .RESET(rst), .PAR_RAW(par_raw), .PCLK(pclk), .H_SYNC(hsync),
      .V_SYNC(vsync), .STAT_VALID(stat_valid), .PIX_SUM(pix_sum), .PIX_MIN(pix_min),
      .PIX_MAX(pix_max), .LINE_CNT(line_cnt), .FRAME_CNT(frame_cnt),
      .LINE_LEN_ERR(line_len_err), .FRAME_LEN_ERR(frame_len_err), .TIMEOUT_ERR(timeout_err)
   );

   always #5 clk = ~clk;

   // Count every STAT_VALID cycle, sampled mid-cycle
   always @(negedge clk) if (stat_valid === 1'b1) pulses <= pulses + 1;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_valid"}, 64'(stat_valid), 0);
      check({tag, "_sum"}, 64'(pix_sum), 0);
      check({tag, "_min"}, 64'(pix_min), 1023);
      check({tag, "_max"}, 64'(pix_max), 0);
      check({tag, "_lines"}, 64'(line_cnt), 0);
      check({tag, "_frames"}, 64'(frame_cnt), 0);
      check({tag, "_errs"}, {61'd0, line_len_err, frame_len_err, timeout_err}, 0);
   endtask

   function automatic int pix_val(input int mode, input int row, input int col);
      if (mode == 0) return row * 4 + col;
      if (mode == 1) return 1023;
      return int'($urandom_range(0, 1023));
   endfunction

   task automatic send_pixel(input int v);
      pclk = 1'b0;
      par_raw = DW'(v);
      tick(4);
      pclk = 1'b1;
      tick(4);
   endtask

   // When joint is set, H_SYNC and V_SYNC drop together and no time passes after
   task automatic send_line(input int len, input int row, input int mode, input bit joint);
      int v;
      hsync = 1'b1;
      tick(3);
      for (int c = 0; c < len; c++) begin
         v = pix_val(mode, row, c);
         pix_vals.push_back(v);
         send_pixel(v);
      end
      pclk = 1'b0;
      tick(3);
      line_lens.push_back(len);
      hsync = 1'b0;
      if (joint) vsync = 1'b0;
      else tick(6);
   endtask

   task automatic send_frame(input int nlines, input int short_row, input int short_len,
                             input int mode, input bit joint, input bit rand_lens);
      int len;
      pix_vals.delete();
      line_lens.delete();
      vsync = 1'b1;
      tick(6);
      for (int r = 0; r < nlines; r++) begin
         if (rand_lens) len = int'($urandom_range(2, 5));
         else len = (r == short_row) ? short_len : int'(COLS);
         send_line(len, r, mode, joint && (r == nlines - 1));
      end
      if (!joint) begin
         tick(3);
         vsync = 1'b0;
      end
   endtask

   // Wait for a publish lat_exp cycles after the last drive and compare all fields
   task automatic expect_publish(input string tag, input int lat_exp, input bit exp_tmo);
      int lat = -1;
      longint s = 0;
      int mn = 1023, mx = 0, nl;
      bit lerr = 1'b0;
      for (int i = 1; i <= lat_exp + 20; i++) begin
         tick(1);
         if (stat_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
      foreach (pix_vals[k]) begin
         s += pix_vals[k];
         if (pix_vals[k] < mn) mn = pix_vals[k];
         if (pix_vals[k] > mx) mx = pix_vals[k];
      end
      if (s > 64'h7FF_FFFF) s = 64'h7FF_FFFF;
      nl = line_lens.size();
      foreach (line_lens[k]) if (line_lens[k] != int'(COLS)) lerr = 1'b1;
      exp_frames = (exp_frames + 1) % 65536;
      exp_pulses++;
      if (lat >= 0) begin
         check({tag, "_sum"}, 64'(pix_sum), 64'(s));
         check({tag, "_min"}, 64'(pix_min), 64'(mn));
         check({tag, "_max"}, 64'(pix_max), 64'(mx));
         check({tag, "_lines"}, 64'(line_cnt), 64'(nl > 2047 ? 2047 : nl));
         check({tag, "_frames"}, 64'(frame_cnt), 64'(exp_frames));
         check({tag, "_line_err"}, 64'(line_len_err), 64'(lerr));
         check({tag, "_frame_err"}, 64'(frame_len_err), 64'(nl != int'(ROWS)));
         check({tag, "_tmo_err"}, 64'(timeout_err), 64'(exp_tmo));
      end
      tick(1);
      check({tag, "_width"}, 64'(stat_valid), 0);
      check({tag, "_pulses"}, 64'(pulses), 64'(exp_pulses));
   endtask

   initial begin
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2);
      check_reset_vals("reset");
      check("reset_pulses", 64'(pulses), 0);

      send_frame(4, -1, 0, 0, 1'b0, 1'b0);
      expect_publish("nominal", 4, 1'b0);
      tick(10);

      send_frame(4, 2, 3, 0, 1'b0, 1'b0);
      expect_publish("short_line", 4, 1'b0);
      check("short_line_sum109", 64'(pix_sum), 109);
      tick(10);

      send_frame(5, -1, 0, 1, 1'b0, 1'b0);
      expect_publish("five_lines", 4, 1'b0);
      tick(10);

      send_frame(4, -1, 0, 0, 1'b1, 1'b0);
      expect_publish("joint_end", 4, 1'b0);
      tick(10);

      for (int k = 0; k < 3; k++) begin
         send_frame(int'($urandom_range(3, 5)), -1, 0, 2, 1'b0, 1'b1);
         expect_publish($sformatf("random%0d", k), 4, 1'b0);
         tick(10);
      end

      // Timeout: V_SYNC held high, publish 4 sync cycles + TMO frame cycles later
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      exp_frames = 0;
      tick(2);
      pix_vals.delete();
      line_lens.delete();
      vsync = 1'b1;
      expect_publish("timeout", 4 + int'(TMO), 1'b1);
      tick(20);
      vsync = 1'b0;
      tick(20);
      check("timeout_no_restart", 64'(pulses), 64'(exp_pulses));
      send_frame(4, -1, 0, 2, 1'b0, 1'b0);
      expect_publish("after_timeout", 4, 1'b0);
      tick(10);

      // Reset during line 3 discards the frame; bus goes quiet while reset is held
      pix_vals.delete();
      line_lens.delete();
      vsync = 1'b1;
      tick(6);
      send_line(4, 0, 0, 1'b0);
      send_line(4, 1, 0, 1'b0);
      hsync = 1'b1;
      tick(3);
      send_pixel(8);
      send_pixel(9);
      rst = 1'b1;
      tick(2);
      pclk = 1'b0;
      hsync = 1'b0;
      vsync = 1'b0;
      tick(4);
      rst = 1'b0;
      exp_frames = 0;
      tick(12);
      check("midreset_pulses", 64'(pulses), 64'(exp_pulses));
      check_reset_vals("midreset");
      send_frame(4, -1, 0, 0, 1'b0, 1'b0);
      expect_publish("after_midreset", 4, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
